// File: rtl/shared_reg_arbiter.sv
// shared_reg_arbiter: round-robin arbiter and write sequencer for one shared register
//   clk     - rising-edge clock
//   reset   - asynchronous, active-low reset
//   req     - per-requester ownership request
//   wdata   - requester i data on [i*WIDTH +: WIDTH]
//   gnt     - registered one-hot (or zero) grant to the current owner
//   q       - the shared register
//   owner   - index of the current or last owner
//   busy    - high while not IDLE
//   preempt - one-cycle pulse when a grant ends on the MAX_HOLD limit
module shared_reg_arbiter #(
    parameter int N_REQ    = 4,
    parameter int WIDTH    = 8,
    parameter int MAX_HOLD = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*WIDTH-1:0] wdata,
    output logic [N_REQ-1:0]       gnt,
    output logic [WIDTH-1:0]       q,
    output logic [2:0]             owner,
    output logic                   busy,
    output logic                   preempt
);
    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;
    state_t           state_q;
    logic [2:0]       ptr_q;
    logic [3:0]       hold_q;
    logic [2:0]       win_d;
    logic [2:0]       idx;
    logic             found;
    logic             last_load;
    logic [7:0]       req_pad;
    logic [WIDTH-1:0] slice [8];
    // Padding to 8 entries lets the 3-bit owner index everything without width games.
    assign req_pad   = 8'(req);
    assign last_load = req_pad[owner] && hold_q == 4'(MAX_HOLD - 1);
    for (genvar g = 0; g < 8; g++) begin : g_slice
        if (g < N_REQ) begin : g_used
            assign slice[g] = wdata[g*WIDTH +: WIDTH];
        end else begin : g_unused
            assign slice[g] = '0;
        end
    end
    // First requester found scanning ptr, ptr+1, ... modulo N_REQ.
    always_comb begin
        win_d = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 0; i < N_REQ; i++) begin
            idx = 3'((int'(ptr_q) + i) % N_REQ);
            if (!found && req_pad[idx]) begin
                found = 1'b1;
                win_d = idx;
            end
        end
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            gnt     <= '0;
            q       <= '0;
            owner   <= '0;
            busy    <= 1'b0;
            preempt <= 1'b0;
            ptr_q   <= '0;
            hold_q  <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (found) begin
                        state_q <= GRANT;
                        gnt     <= N_REQ'(1) << win_d;
                        owner   <= win_d;
                        hold_q  <= '0;
                        busy    <= 1'b1;
                    end
                end
                GRANT: begin
                    if (req_pad[owner]) begin
                        q      <= slice[owner];
                        hold_q <= hold_q + 4'd1;
                    end
                    // A dropped request ends the grant voluntarily; only the limit preempts.
                    if (!req_pad[owner] || last_load) begin
                        state_q <= RELEASE;
                        gnt     <= '0;
                    end
                    preempt <= last_load;
                end
                RELEASE: begin
                    preempt <= 1'b0;
                    ptr_q   <= (owner == 3'(N_REQ - 1)) ? 3'd0 : owner + 3'd1;
                    state_q <= IDLE;
                    busy    <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule
